// File: rtl/store_align_unit_if.sv
// Store request / memory write-beat bundle for store_align_unit.
// slave = the align unit, master = the request/memory side.
interface store_align_unit_if;
    logic        i_st_valid;
    logic        o_st_ready;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_mask;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_split;
    logic        o_done;

    modport slave (
        input  i_st_valid,
        input  i_addr,
        input  i_wdata,
        input  i_mask,
        input  i_mem_ready,
        output o_st_ready,
        output o_mem_valid,
        output o_mem_addr,
        output o_mem_wdata,
        output o_mem_bmask,
        output o_split,
        output o_done
    );

    modport master (
        output i_st_valid,
        output i_addr,
        output i_wdata,
        output i_mask,
        output i_mem_ready,
        input  o_st_ready,
        input  o_mem_valid,
        input  o_mem_addr,
        input  o_mem_wdata,
        input  o_mem_bmask,
        input  o_split,
        input  o_done
    );
endinterface

// File: rtl/store_align_unit.sv
// Store alignment: lane-positions store data/byte-enables and
// issues one or two word-aligned write beats (split on crossing).
module store_align_unit (
    input  logic i_clk,
    input  logic i_reset,
    store_align_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [3:0]  norm_mask;
    logic [63:0] sh_data;
    logic [7:0]  sh_mask;
    logic [63:0] lane_data;
    logic [31:0] base_addr;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  bmask_q;
    logic [31:0] hi_addr_q;
    logic [31:0] hi_wdata_q;
    logic [3:0]  hi_bmask_q;
    logic        split_q;
    logic        done_q;

    logic accept;
    logic beat_hs;
    logic final_hs;

    assign accept   = bus.i_st_valid && (state_q == IDLE);
    assign beat_hs  = (state_q != IDLE) && bus.i_mem_ready;
    assign final_hs = beat_hs && ((state_q == BEAT1) || !split_q);

    // Normalize size code and spread data/enables over two word lanes
    always_comb begin
        norm_mask = 4'b1111;
        case (bus.i_mask)
            4'b0001: norm_mask = 4'b0001;
            4'b0011: norm_mask = 4'b0011;
            default: norm_mask = 4'b1111;
        endcase
        base_addr = {bus.i_addr[31:2], 2'b00};
        sh_data   = {32'b0, bus.i_wdata} << {bus.i_addr[1:0], 3'b000};
        sh_mask   = {4'b0, norm_mask} << bus.i_addr[1:0];
        lane_data = '0;
        for (int k = 0; k < 8; k++) begin
            lane_data[8*k +: 8] = sh_data[8*k +: 8] & {8{sh_mask[k]}};
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.i_st_valid) state_d = BEAT0;
            end
            BEAT0: begin
                if (bus.i_mem_ready) state_d = split_q ? BEAT1 : IDLE;
            end
            BEAT1: begin
                if (bus.i_mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat registers: load beat 0 on accept, swap in beat 1 after beat 0
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            bmask_q    <= '0;
            hi_addr_q  <= '0;
            hi_wdata_q <= '0;
            hi_bmask_q <= '0;
        end else if (accept) begin
            addr_q     <= base_addr;
            wdata_q    <= lane_data[31:0];
            bmask_q    <= sh_mask[3:0];
            hi_addr_q  <= base_addr + 32'd4;
            hi_wdata_q <= lane_data[63:32];
            hi_bmask_q <= sh_mask[7:4];
        end else if (state_q == BEAT0 && bus.i_mem_ready && split_q) begin
            addr_q  <= hi_addr_q;
            wdata_q <= hi_wdata_q;
            bmask_q <= hi_bmask_q;
        end
    end

    // Split flag held for the request; done pulses after the last beat
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            split_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= final_hs;
            if (accept) begin
                split_q <= |sh_mask[7:4];
            end else if (final_hs) begin
                split_q <= 1'b0;
            end
        end
    end

    assign bus.o_st_ready  = (state_q == IDLE);
    assign bus.o_mem_valid = (state_q != IDLE);
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign bus.o_mem_bmask = bmask_q;
    assign bus.o_split     = split_q;
    assign bus.o_done      = done_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench for store_align_unit: directed cases plus
// random stores against a per-byte reference model.
module tb_store_align_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    store_align_unit_if bus();

    store_align_unit dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: place each stored byte at its own byte address,
    // then group bytes by the word they land in.
    task automatic model(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, output int nb,
                         output logic [31:0] ea [2],
                         output logic [31:0] ed [2],
                         output logic [3:0] em [2]);
        int size;
        logic [31:0] base;
        logic [31:0] ba;
        int idx;
        int lane;
        size = (mask == 4'b0001) ? 1 : (mask == 4'b0011) ? 2 : 4;
        base = addr & 32'hFFFF_FFFC;
        ea[0] = base;
        ea[1] = base + 32'd4;
        ed[0] = '0;
        ed[1] = '0;
        em[0] = '0;
        em[1] = '0;
        nb = 1;
        for (int j = 0; j < size; j++) begin
            ba = addr + j;
            idx = ((ba & 32'hFFFF_FFFC) == base) ? 0 : 1;
            lane = int'(ba % 4);
            ed[idx][8*lane +: 8] = data[8*j +: 8];
            em[idx][lane] = 1'b1;
            if (idx == 1) nb = 2;
        end
    endtask

    task automatic run_store(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input int stall_max);
        int nb;
        int stall;
        logic [31:0] ea [2];
        logic [31:0] ed [2];
        logic [3:0]  em [2];
        model(addr, data, mask, nb, ea, ed, em);
        chk("idle_ready", 32'(bus.o_st_ready), 32'd1);
        bus.i_st_valid  = 1'b1;
        bus.i_addr      = addr;
        bus.i_wdata     = data;
        bus.i_mask      = mask;
        bus.i_mem_ready = 1'b0;
        step();
        for (int b = 0; b < nb; b++) begin
            stall = (stall_max < 0) ? -stall_max
                                    : int'($urandom_range(stall_max, 0));
            for (int s = 0; s <= stall; s++) begin
                chk("mem_valid", 32'(bus.o_mem_valid), 32'd1);
                chk("st_ready_busy", 32'(bus.o_st_ready), 32'd0);
                chk("mem_addr", bus.o_mem_addr, ea[b]);
                chk("mem_wdata", bus.o_mem_wdata, ed[b]);
                chk("mem_bmask", 32'(bus.o_mem_bmask), 32'(em[b]));
                chk("split", 32'(bus.o_split), 32'(nb == 2));
                chk("done_busy", 32'(bus.o_done), 32'd0);
                bus.i_st_valid  = 1'($urandom_range(1, 0));
                bus.i_addr      = $urandom;
                bus.i_wdata     = $urandom;
                bus.i_mask      = 4'($urandom);
                bus.i_mem_ready = (s == stall);
                step();
            end
        end
        bus.i_st_valid  = 1'b0;
        bus.i_mem_ready = 1'b0;
        chk("done_pulse", 32'(bus.o_done), 32'd1);
        chk("done_ready", 32'(bus.o_st_ready), 32'd1);
        chk("done_valid", 32'(bus.o_mem_valid), 32'd0);
        chk("done_split", 32'(bus.o_split), 32'd0);
    endtask

    logic [3:0] rmask;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.i_st_valid  = 1'b0;
        bus.i_addr      = '0;
        bus.i_wdata     = '0;
        bus.i_mask      = '0;
        bus.i_mem_ready = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(bus.o_st_ready), 32'd1);
        chk("rst_valid", 32'(bus.o_mem_valid), 32'd0);
        chk("rst_addr", bus.o_mem_addr, 32'd0);
        chk("rst_wdata", bus.o_mem_wdata, 32'd0);
        chk("rst_bmask", 32'(bus.o_mem_bmask), 32'd0);
        chk("rst_split", 32'(bus.o_split), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        rst_n = 1'b1;
        step();

        run_store(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111, 0);
        step();
        chk("done_once", 32'(bus.o_done), 32'd0);
        run_store(32'h0000_2002, 32'h0000_00A5, 4'b0001, 0);
        run_store(32'h0000_3003, 32'h0000_1234, 4'b0011, 0);
        run_store(32'hFFFF_FFFD, 32'h1122_3344, 4'b1111, -3);
        run_store(32'h0000_4000, 32'hCAFE_F00D, 4'b0101, 0);
        run_store(32'h0000_6001, 32'hFFFF_ABCD, 4'b0011, 1);

        // Abandon a split store while its second beat is pending
        bus.i_st_valid  = 1'b1;
        bus.i_addr      = 32'h0000_5003;
        bus.i_wdata     = 32'h0000_BEEF;
        bus.i_mask      = 4'b0011;
        step();
        bus.i_st_valid  = 1'b0;
        bus.i_mem_ready = 1'b1;
        step();
        bus.i_mem_ready = 1'b0;
        chk("pre_rst_valid", 32'(bus.o_mem_valid), 32'd1);
        chk("pre_rst_addr", bus.o_mem_addr, 32'h0000_5004);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.o_mem_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.o_st_ready), 32'd1);
        chk("mid_rst_split", 32'(bus.o_split), 32'd0);
        chk("mid_rst_done", 32'(bus.o_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            bus.i_mem_ready = 1'b1;
            step();
            chk("rst_hold_done", 32'(bus.o_done), 32'd0);
            chk("rst_hold_valid", 32'(bus.o_mem_valid), 32'd0);
        end
        bus.i_mem_ready = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_done", 32'(bus.o_done), 32'd0);
        run_store(32'h0000_7002, 32'h8765_4321, 4'b1111, 2);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(3, 0))
                0: rmask = 4'b0001;
                1: rmask = 4'b0011;
                2: rmask = 4'b1111;
                default: rmask = 4'($urandom);
            endcase
            run_store($urandom, $urandom, rmask, 3);
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_align_unit.md
# store_align_unit

Store-side counterpart of the load-data extractor in the LSU: takes a store request (byte address, register data, size mask), positions the data and byte-enables on 32-bit word lanes, and issues one or two word-aligned write beats to data memory through a valid/ready handshake. Misaligned halfword and word stores that cross a word boundary are split into two beats automatically. The block sits between the execute stage's store request and the data-memory write port.

## Interface
- No parameters.
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_st_valid  in  1  store request valid
- o_st_ready  out  1  unit can accept a request (high only in IDLE)
- i_addr  in  32  byte address of the store
- i_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- i_mask  in  4  size: 4'b0001 byte, 4'b0011 halfword, 4'b1111 word; any other code is treated as word
- o_mem_valid  out  1  write beat valid
- i_mem_ready  in  1  memory accepts beat
- o_mem_addr  out  32  word-aligned beat address ([1:0] always 2'b00)
- o_mem_wdata  out  32  lane-positioned write data
- o_mem_bmask  out  4  byte enables, bit k enables byte lane k ([8k+7:8k])
- o_split  out  1  current request is a two-beat store (valid while o_mem_valid)
- o_done  out  1  one-cycle pulse: request fully written

## Operation
- Request accepted on i_st_valid && o_st_ready; i_addr, i_wdata, normalized mask captured into registers.
- off = i_addr[1:0]. Build 64-bit shifted data D = {32'b0, i_wdata} << (8*off) and 8-bit shifted mask M = {4'b0, mask} << off.
- Beat 0: addr = {i_addr[31:2], 2'b00}, wdata = D[31:0], bmask = M[3:0].
- Beat 1 (only if M[7:4] != 0): addr = {i_addr[31:2], 2'b00} + 4 (mod 2^32), wdata = D[63:32], bmask = M[7:4].
- Byte lanes with bmask bit 0 carry 0 in o_mem_wdata.
- FSM states: IDLE, BEAT0, BEAT1.
  - IDLE: o_st_ready=1, o_mem_valid=0. Accept -> BEAT0.
  - BEAT0: o_mem_valid=1. On i_mem_ready: -> BEAT1 if split, else -> IDLE with o_done.
  - BEAT1: o_mem_valid=1. On i_mem_ready: -> IDLE with o_done.
- o_split = registered (M[7:4] != 0), held for whole request; 0 in IDLE.
- Reset (any time, including mid-request): state -> IDLE immediately; in-flight store is abandoned, no further beats.

## Timing
- Reset values: o_st_ready=1, o_mem_valid=0, o_mem_addr=0, o_mem_wdata=0, o_mem_bmask=0, o_split=0, o_done=0.
- Request accepted at edge N -> o_mem_valid high from cycle N+1.
- Beat outputs (addr, wdata, bmask) stable while o_mem_valid && !i_mem_ready; a beat may stall indefinitely.
- Handshake completes in any cycle where o_mem_valid && i_mem_ready; next beat (BEAT1) presented the following cycle, no bubble.
- o_done: registered, high exactly one cycle, the cycle after the final beat handshake; coincides with o_st_ready returning high.
- Minimum throughput: aligned store every 2 cycles (accept, beat); split store every 3 cycles.
- o_st_ready is a pure function of state; i_st_valid ignored outside IDLE.
- Address wrap: beat-1 address wraps 0xFFFFFFFC -> 0x00000000 without fault.

## Test plan
- Aligned word: addr 0x1000, data 0xDEADBEEF, mask 1111, ready=1 -> one beat addr 0x1000, wdata 0xDEADBEEF, bmask 1111, o_split=0; o_done one cycle after handshake.
- Byte at offset 2: addr 0x2002, data 0x000000A5, mask 0001 -> addr 0x2000, wdata 0x00A50000, bmask 0100.
- Split half: addr 0x3003, data 0x00001234, mask 0011 -> beat0 addr 0x3000 wdata 0x34000000 bmask 1000; beat1 addr 0x3004 wdata 0x00000012 bmask 0001; o_split=1 both beats.
- Split word with stall and wrap: addr 0xFFFFFFFD, data 0x11223344, i_mem_ready low 3 cycles per beat -> beat0 0xFFFFFFFC/0x22334400/1110 held stable while stalled; beat1 0x00000000/0x00000011/0001; o_st_ready low throughout.
- Invalid mask 0101 at addr 0x4000, data 0xCAFEF00D -> treated as word: bmask 1111, wdata 0xCAFEF00D.
- Reset mid-split: assert i_reset low while in BEAT1 -> o_mem_valid drops immediately, o_st_ready=1, o_done never pulses; next request after release executes normally.
